// File: rtl/sample_buffer_ctrl.sv
// Sample ring between the Pi deserializer and the I2S transmitter: prefill,
// paced playback on frame_tick, underrun recovery, flush and refill interrupt.
module sample_buffer_ctrl #(
   parameter int DATA_W    = 24,
   parameter int ADDR_W    = 6,
   parameter int PREFILL   = 32,
   parameter int LOW_WATER = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              wr_valid_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              wr_ready_o,
   input  logic              frame_tick_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   output logic              rpi_interrupt_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overrun_o,
   output logic              underrun_o,
   input  logic              clr_status_i,
   output logic [1:0]        state_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_FILL = 2'b01;
   localparam logic [1:0] ST_RUN  = 2'b10;
   localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PREFILL_C   = (ADDR_W+1)'(PREFILL);
   localparam logic [ADDR_W:0] LOW_WATER_C = (ADDR_W+1)'(LOW_WATER);
   localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              irq_q, irq_d;
   logic              ovr_q, ovr_d, und_q, und_d;

   logic [ADDR_W:0]   level_s;
   logic              empty_s, full_s, wr_ready_s, push_s;

   // Occupancy flags all derive from the start-of-cycle pointers.
   always_comb begin
      level_s    = wr_ptr_q - rd_ptr_q;
      empty_s    = (level_s == {(ADDR_W+1){1'b0}});
      full_s     = (level_s == DEPTH_C);
      wr_ready_s = enable_i && (state_q != ST_IDLE) && !full_s;
      push_s     = wr_valid_i && wr_ready_s;
   end

   // Next-state logic: sequencing, pointer updates, playback and status flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      irq_d       = (state_q != ST_IDLE) && (level_s < LOW_WATER_C);
      ovr_d       = ovr_q && !clr_status_i;
      und_d       = und_q && !clr_status_i;
      if (!enable_i) begin
         wr_ptr_d = {(ADDR_W+1){1'b0}};
         rd_ptr_d = {(ADDR_W+1){1'b0}};
         state_d  = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_FILL;
            end
            ST_FILL: begin
               if (frame_tick_i) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {DATA_W{1'b0}};
               end else begin
                  out_valid_d = 1'b0;
               end
               if (level_s >= PREFILL_C) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_RUN: begin
               if (frame_tick_i && empty_s) begin
                  out_valid_d = 1'b1;
                  out_data_d  = {DATA_W{1'b0}};
                  und_d       = 1'b1;
                  state_d     = ST_FILL;
               end else if (frame_tick_i) begin
                  out_valid_d = 1'b1;
                  out_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                  rd_ptr_d    = rd_ptr_q + PTR_ONE;
               end else begin
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         // A refused word only counts as overrun once the block is running.
         if (wr_valid_i && (state_q != ST_IDLE) && full_s) begin
            ovr_d = 1'b1;
         end else begin
            ovr_d = ovr_d;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= {(ADDR_W+1){1'b0}};
         rd_ptr_q    <= {(ADDR_W+1){1'b0}};
         state_q     <= ST_IDLE;
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         irq_q       <= 1'b0;
         ovr_q       <= 1'b0;
         und_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         irq_q       <= irq_d;
         ovr_q       <= ovr_d;
         und_q       <= und_d;
      end
   end

   // Sample storage carries no reset; stale words are unreachable after a flush.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
      end
   end

   assign wr_ready_o      = wr_ready_s;
   assign out_data_o      = out_data_q;
   assign out_valid_o     = out_valid_q;
   assign rpi_interrupt_o = irq_q;
   assign level_o         = level_s;
   assign overrun_o       = ovr_q;
   assign underrun_o      = und_q;
   assign state_o         = state_q;

endmodule

// File: doc/sample_buffer_ctrl.md
Name: sample_buffer_ctrl

Overview:
- Single-clock controller and storage for the 24-bit audio sample ring between the Raspberry Pi deserializer and the I2S transmit side.
- Accepts deserialized words and paces them out on the transmitter's frame request.
- Sequences startup prefill, underrun recovery and flush.
- Raises the Pi refill interrupt when occupancy drops below a low-water mark.
- All inputs are already synchronous to clk; CDC is handled upstream.

Parameters:
DATA_W, 24, sample width in bits
ADDR_W, 6, log2 of ring depth (depth = 64)
PREFILL, 32, occupancy required before leaving FILL; legal range 1..2^ADDR_W
LOW_WATER, 32, rpi_interrupt asserted while occupancy < LOW_WATER; legal range 1..2^ADDR_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  run control; low flushes the ring and parks the block in IDLE
wr_valid  in  1  deserialized word available
wr_data  in  DATA_W  deserialized word
wr_ready  out  1  ring can accept a word this cycle (combinational)
frame_tick  in  1  one-cycle request for the next sample from the I2S side
out_data  out  DATA_W  sample delivered to the I2S side
out_valid  out  1  one-cycle strobe qualifying out_data
rpi_interrupt  out  1  refill request to the Pi (registered)
level  out  ADDR_W+1  current occupancy, 0..2^ADDR_W
overrun  out  1  sticky: a word was offered while the ring was full
underrun  out  1  sticky: a frame_tick arrived in RUN with an empty ring
clr_status  in  1  clears overrun and underrun
state  out  2  00 IDLE, 01 FILL, 10 RUN

Behaviour:
- Reset (rst_n low, asynchronous), all of the following held until release:
  - wr_ptr = rd_ptr = 0; state = IDLE.
  - out_data = 0, out_valid = 0, rpi_interrupt = 0, overrun = 0, underrun = 0.
  - Memory contents are undefined.
- Pointers are ADDR_W+1 bits wide and wrap modulo 2^(ADDR_W+1).
  - level = wr_ptr - rd_ptr.
  - empty: level == 0; full: level == 2^ADDR_W.
  - Memory address = low ADDR_W bits of the pointer.
- wr_ready = enable && state != IDLE && !full. It is computed from the start-of-cycle level.
- Write: wr_valid && wr_ready stores wr_data at wr_ptr and increments wr_ptr.
  - wr_valid while full (state != IDLE): word dropped, overrun set.
  - wr_valid while IDLE or !enable: word dropped silently.
- State transitions:
  - IDLE -> FILL when enable = 1.
  - FILL -> RUN when level >= PREFILL.
  - RUN -> FILL on underrun.
  - Any state -> IDLE on the edge where enable = 0. The same edge zeroes both pointers (flush) and ignores that cycle's write and tick.
- frame_tick response (out_valid pulses exactly 1 cycle after each accepted tick):
  - IDLE: tick ignored, no out_valid.
  - FILL: out_data = 0 (silence), out_valid = 1, no pop.
  - RUN, level > 0: out_data = mem[rd_ptr], out_valid = 1, rd_ptr increments.
  - RUN, level == 0: out_data = 0, out_valid = 1, underrun set, state -> FILL.
- Simultaneous write and pop:
  - Both are performed and level is unchanged.
  - Empty test uses the start-of-cycle level, so a write into an empty ring on the same cycle as a RUN tick still underruns.
  - The full test likewise uses the start-of-cycle level.
- A pop never reads the location written in the same cycle.
- rpi_interrupt <= (state != IDLE) && (level < LOW_WATER), evaluated on the start-of-cycle level. It therefore lags level by one cycle.
- clr_status clears both sticky flags. A new overrun or underrun event in the same cycle wins and the flag stays set.
- out_data holds its last value when out_valid = 0.
- Reset asserted mid-operation discards all contents immediately. After release the block restarts in IDLE with no out_valid pending.

Test Plan:
- Reset then enable = 1, 32 writes (0x000001..0x000020), then ticks: state 01 until the 32nd write, state 10 the cycle after. The first 3 ticks return 0x000001, 0x000002, 0x000003, each with out_valid one cycle after its tick. level reads 29.
- Ticks during FILL with level = 10: out_data = 0, out_valid = 1, level stays 10. rpi_interrupt = 1 while level < 32 and drops one cycle after level reaches 32.
- Fill to 64, hold wr_valid high: wr_ready = 0, overrun = 1, level stays 64. A tick plus a write on the same cycle pops one word and accepts none. The next write is then accepted and level returns to 64.
- RUN with level = 1: two ticks pop the last word, then return out_data = 0 with underrun = 1 and state = 01. clr_status clears underrun. A clr_status coinciding with a second underrun leaves the flag at 1.
- Wrap-around: stream 200 writes and 200 ticks interleaved at level ≈ 40. Output order matches input order and level never exceeds 64.
- Deassert enable mid-RUN at level 20: the next cycle shows state 00, level 0, wr_ready 0, and ticks produce no out_valid. Repeat the same sequence with rst_n pulsed low instead of enable low: all outputs are at reset values during the reset pulse.
